// File: rtl/plot_arbiter.sv
// Round-robin arbiter for the two pixel producers sharing the VGA adapter write port,
// with a built-in full-frame clear sequencer that preempts both producers.
module plot_arbiter #(
   parameter int unsigned   XW           = 6,
   parameter int unsigned   YW           = 5,
   parameter int unsigned   CW           = 3,
   parameter int unsigned   X_MAX        = 63,
   parameter int unsigned   Y_MAX        = 31,
   parameter logic [CW-1:0] CLEAR_COLOUR = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid_i,
   input  logic [XW-1:0] req0_x_i,
   input  logic [YW-1:0] req0_y_i,
   input  logic [CW-1:0] req0_colour_i,
   output logic          req0_ready_c_o,
   input  logic          req1_valid_i,
   input  logic [XW-1:0] req1_x_i,
   input  logic [YW-1:0] req1_y_i,
   input  logic [CW-1:0] req1_colour_i,
   output logic          req1_ready_c_o,
   input  logic          clear_start_i,
   output logic          clear_busy_o,
   output logic          clear_done_o,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic [CW-1:0] colour_o,
   output logic          plot_o
);

   typedef enum logic {ST_ARB, ST_CLEAR} state_e;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [CW-1:0] colour;
   } pixel_t;

   state_e        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [XW-1:0] cx_q, cx_d;
   logic [YW-1:0] cy_q, cy_d;
   pixel_t        pix_q, pix_d;
   logic          plot_q, plot_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   pixel_t        req0_pix, req1_pix;
   logic          gnt0, gnt1;

   assign req0_pix = '{x: req0_x_i, y: req0_y_i, colour: req0_colour_i};
   assign req1_pix = '{x: req1_x_i, y: req1_y_i, colour: req1_colour_i};

   // Grant from registered state and valids only; on a tie the producer not served last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == ST_ARB) begin
         if (req0_valid_i && req1_valid_i) begin
            gnt0 = last_grant_q;
            gnt1 = ~last_grant_q;
         end else begin
            gnt0 = req0_valid_i;
            gnt1 = req1_valid_i;
         end
      end
   end

   assign req0_ready_c_o = gnt0;
   assign req1_ready_c_o = gnt1;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      pix_d        = pix_q;
      plot_d       = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;
      case (state_q)
         ST_ARB: begin
            if (gnt0) begin
               pix_d        = req0_pix;
               plot_d       = 1'b1;
               last_grant_d = 1'b0;
            end else if (gnt1) begin
               pix_d        = req1_pix;
               plot_d       = 1'b1;
               last_grant_d = 1'b1;
            end
            // A transfer granted this cycle still completes before the sweep begins.
            if (clear_start_i) begin
               state_d = ST_CLEAR;
               cx_d    = '0;
               cy_d    = '0;
               busy_d  = 1'b1;
            end
         end
         ST_CLEAR: begin
            pix_d  = '{x: cx_q, y: cy_q, colour: CLEAR_COLOUR};
            plot_d = 1'b1;
            if (cx_q == XW'(X_MAX)) begin
               cx_d = '0;
               if (cy_q == YW'(Y_MAX)) begin
                  cy_d    = '0;
                  state_d = ST_ARB;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  cy_d = cy_q + YW'(1);
               end
            end else begin
               cx_d = cx_q + XW'(1);
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_ARB;
         last_grant_q <= 1'b1;
         cx_q         <= '0;
         cy_q         <= '0;
         pix_q        <= '0;
         plot_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         pix_q        <= pix_d;
         plot_q       <= plot_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign x_o          = pix_q.x;
   assign y_o          = pix_q.y;
   assign colour_o     = pix_q.colour;
   assign plot_o       = plot_q;
   assign clear_busy_o = busy_q;
   assign clear_done_o = done_q;

endmodule
